// File: rtl/cpu_mdu_iter_if.sv
// Request/response bundle between the EX stage (master) and the iterative
// multiply/divide unit (slave).
interface cpu_mdu_iter_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      control;
    logic            op_w;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, control, op_w, operand_a, operand_b, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, control, op_w, operand_a, operand_b, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/cpu_mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, BITS_PER_CYCLE bits retired per CALC cycle.
module cpu_mdu_iter #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int ENABLE_W       = 1
) (
    input  logic           clk,
    input  logic           reset,
    cpu_mdu_iter_if.slave  bus
);
    localparam int N_FULL = XLEN / BITS_PER_CYCLE;
    localparam int N_WORD = 32 / BITS_PER_CYCLE;
    localparam int CNT_W  = $clog2(N_FULL) + 1;
    localparam logic W_OK = (XLEN == 64) && (ENABLE_W != 0);
    localparam logic [XLEN-1:0] MIN_FULL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_WORD  = XLEN'(32'h8000_0000);
    localparam logic [XLEN-1:0] ONES_WORD = XLEN'(32'hFFFF_FFFF);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        ctl_q;
    logic              wop_q, neg_q;
    logic [XLEN-1:0]   opa_q, opb_q, result_q;
    logic [2*XLEN-1:0] acc_q, acc_it;
    logic [XLEN-1:0]   opb_it;
    logic [CNT_W-1:0]  cnt_q;
    logic              in_ready, out_valid, busy;

    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v, input logic w);
        return w ? XLEN'($signed(v[31:0])) : v;
    endfunction

    // Two's-complement magnitude; word ops keep only the low 32 bits.
    function automatic logic [XLEN-1:0] to_mag(input logic [XLEN-1:0] v, input logic neg,
                                               input logic w);
        logic [XLEN-1:0] m;
        m = neg ? -v : v;
        if (w) m = XLEN'(m[31:0]);
        return m;
    endfunction

    function automatic logic [XLEN-1:0] fixup(input logic [2*XLEN-1:0] acc, input logic [2:0] ctl,
                                              input logic w, input logic neg);
        logic [XLEN-1:0]   v;
        logic [2*XLEN-1:0] p;
        if (ctl[2]) begin
            v = ctl[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
            v = neg ? -v : v;
        end else if (ctl[1:0] == 2'd0 || w) begin
            v = acc[XLEN-1:0];
        end else begin
            p = neg ? -acc : acc;
            v = p[2*XLEN-1:XLEN];
        end
        return sext_word(v, w);
    endfunction

    // Operand preparation for the request currently presented.
    logic            wop_in, mul_hi_in, a_neg, b_neg, neg_in, b_zero, ovf, fast_in, accept;
    logic [XLEN-1:0] a_w, b_w, a_mag, b_mag, fast_res;
    int              sh;

    always_comb begin
        wop_in    = W_OK && bus.op_w;
        a_w       = wop_in ? XLEN'(bus.operand_a[31:0]) : bus.operand_a;
        b_w       = wop_in ? XLEN'(bus.operand_b[31:0]) : bus.operand_b;
        mul_hi_in = !bus.control[2] && (bus.control[1:0] != 2'd0) && !wop_in;
        a_neg     = ((mul_hi_in && (bus.control[1:0] != 2'd3)) || (bus.control[2] && !bus.control[0]))
                    && (wop_in ? bus.operand_a[31] : bus.operand_a[XLEN-1]);
        b_neg     = ((mul_hi_in && (bus.control[1:0] == 2'd1)) || (bus.control[2] && !bus.control[0]))
                    && (wop_in ? bus.operand_b[31] : bus.operand_b[XLEN-1]);
        neg_in    = (bus.control[2] && bus.control[1]) ? a_neg : (a_neg ^ b_neg);
        a_mag     = to_mag(a_w, a_neg, wop_in);
        b_mag     = to_mag(b_w, b_neg, wop_in);
        sh        = wop_in ? XLEN - 32 : 0;
        b_zero    = (b_w == '0);
        ovf       = bus.control[2] && !bus.control[0]
                    && (a_w == (wop_in ? MIN_WORD : MIN_FULL))
                    && (wop_in ? (b_w == ONES_WORD) : (&b_w));
        fast_in   = bus.control[2] && (b_zero || ovf);
        if (b_zero) fast_res = bus.control[1] ? sext_word(a_w, wop_in) : '1;
        else        fast_res = bus.control[1] ? '0 : sext_word(a_w, wop_in);
        accept    = (state == IDLE) && bus.in_valid && !bus.flush;
    end

    // One CALC cycle: BITS_PER_CYCLE shift-add or restoring-subtract steps.
    always_comb begin
        logic [XLEN:0] t;
        acc_it = acc_q;
        opb_it = opb_q;
        t      = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (ctl_q[2]) begin
                t = {acc_it[2*XLEN-1:XLEN], acc_it[XLEN-1]};
                if (t >= {1'b0, opb_q})
                    acc_it = {t[XLEN-1:0] - opb_q, acc_it[XLEN-2:0], 1'b1};
                else
                    acc_it = {t[XLEN-1:0], acc_it[XLEN-2:0], 1'b0};
            end else begin
                acc_it = (acc_it << 1) + (opb_it[XLEN-1] ? {{XLEN{1'b0}}, opa_q} : '0);
                opb_it = opb_it << 1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (bus.in_valid) state_nxt = fast_in ? DONE : CALC;
            end
            CALC: if (cnt_q == '0) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_q    <= '0;
            wop_q    <= 1'b0;
            neg_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            ctl_q <= bus.control;
            wop_q <= wop_in;
            neg_q <= neg_in;
            opa_q <= a_mag;
            opb_q <= bus.control[2] ? b_mag : (b_mag << sh);
            acc_q <= bus.control[2] ? {{XLEN{1'b0}}, a_mag << sh} : '0;
            cnt_q <= wop_in ? CNT_W'(N_WORD - 1) : CNT_W'(N_FULL - 1);
            if (fast_in) result_q <= fast_res;
        end else if (state == CALC && !bus.flush) begin
            acc_q <= acc_it;
            opb_q <= opb_it;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) result_q <= fixup(acc_it, ctl_q, wop_q, neg_q);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.result    = result_q;
endmodule
